me_pixel_mem_responder: RTL
===========================

// Module: me_pixel_mem_responder
// PURPOSE
// - Memory-side responder for the ME core fetch interface: answers cur/ref read requests (addr + enable) with pixel words one cycle later.
// - Holds one current block (32-bit words, 4 pixels) and one reference window (64-bit words, 8 pixels) in two register/SRAM banks.
// - The host preloads both banks over a valid/ready load port, then arms SERVE; the ME core reads until the host stops it.
// PARAMETERS
// - CUR_AW 4  : cur bank address width; depth 2**CUR_AW words of 32 bits (16 = one 8x8 block)
// - REF_AW 7  : ref bank address width; depth 2**REF_AW words of 64 bits
// PORTS
// - clk          in   1   clock; all logic on rising edge
// - rst          in   1   synchronous reset, active-low (0 = reset)
// - ld_valid     in   1   host load word valid
// - ld_ready     out  1   load accepted when ld_valid & ld_ready
// - ld_sel       in   1   0 = cur bank, 1 = ref bank
// - ld_addr      in   32  load word address
// - ld_data      in   64  load data; cur bank takes [31:0]; pixel k at [8k+7:8k]
// - go_i         in   1   pulse: IDLE -> SERVE
// - stop_i       in   1   pulse: SERVE -> IDLE
// - cur_mem_en   in   1   ME cur read request
// - cur_mem_addr in   32  ME cur word address
// - ref_mem_en   in   1   ME ref read request
// - ref_mem_addr in   32  ME ref word address
// - cur_in_i     out  32  cur read data (4 pixels)
// - ref_in_i     out  64  ref read data (8 pixels)
// - serving      out  1   high in SERVE
// - addr_err     out  1   sticky: out-of-range or IDLE-state read seen
// - rd_cnt       out  16  served-read counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE; cur_in_i=0, ref_in_i=0, addr_err=0, rd_cnt=0, serving=0; bank contents not cleared.
// - States: IDLE (loading allowed), SERVE (reads served). ld_ready = (state==IDLE) combinationally.
// - IDLE: go_i -> SERVE next cycle. SERVE: stop_i -> IDLE next cycle. go_i in SERVE / stop_i in IDLE ignored.
// - Load: on ld_valid & ld_ready write ld_data to bank ld_sel at ld_addr; ld_addr >= bank depth -> write dropped, addr_err set.
// - Load handshake in the same cycle as go_i: write is performed, then state changes.
// - Read latency exactly 1: request (en, addr) at edge N -> data on cur_in_i/ref_in_i after edge N, valid for cycle N+1.
// - cur and ref ports independent; both may fire in the same cycle.
// - en low: corresponding output holds its last value.
// - SERVE with addr >= depth: output 0, addr_err set. IDLE with any en high: output 0, addr_err set.
// - A load never targets a bank being read (ld_ready=0 in SERVE), so no read/write collision exists.
// - addr_err cleared only by reset.
// - Reset mid-SERVE: next cycle IDLE, outputs 0; in-flight read data discarded.
// CONFIGURATION
// - Macro ME_MEM_RDCNT_EN defined: rd_cnt increments by 1 per cur read and 1 per ref read served in SERVE (+2 when both fire),
//   in range or not; saturates at 16'hFFFF; cleared by reset and on the IDLE->SERVE transition.
// - Macro undefined: rd_cnt tied to 16'h0000, no counter logic.
// TESTING
// - Reset: hold rst=0 2 cycles -> ld_ready=1, serving=0, cur_in_i=0, ref_in_i=0, addr_err=0, rd_cnt=0.
// - Load cur[3]=32'hA1B2C3D4, ref[5]=64'h0102030405060708, go_i; read cur 3 and ref 5 same cycle
//   -> next cycle cur_in_i=32'hA1B2C3D4, ref_in_i=64'h0102030405060708; rd_cnt=2 with macro.
// - Back-to-back cur reads addr 0,1,2 of loaded 32'h10,32'h11,32'h12 -> outputs 32'h10,32'h11,32'h12 in consecutive cycles;
//   drop en -> output holds 32'h12.
// - SERVE, ref_mem_addr=128 (REF_AW=7) -> ref_in_i=0 next cycle, addr_err=1 and stays 1 after stop_i.
// - SERVE: ld_valid=1 -> ld_ready=0, bank unchanged; stop_i then ld_valid -> accepted; IDLE read with cur_mem_en=1 -> cur_in_i=0, addr_err=1.
// - Assert rst=0 mid-SERVE with reads pending -> next cycle IDLE, outputs 0; go_i again -> previously loaded data still read back.

Source files
------------

// File: rtl/me_pixel_mem_responder.sv
// Memory-side responder for the ME fetch port: a preloadable cur bank (32b words) and ref bank (64b words), read with 1-cycle latency.
// Optional served-read counter on rd_cnt is built when ME_MEM_RDCNT_EN is defined; otherwise rd_cnt is tied to zero.
module me_pixel_mem_responder #(
  parameter int CUR_AW = 4,
  parameter int REF_AW = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic        ld_sel,
  input  logic [31:0] ld_addr,
  input  logic [63:0] ld_data,
  input  logic        go_i,
  input  logic        stop_i,
  input  logic        cur_mem_en,
  input  logic [31:0] cur_mem_addr,
  input  logic        ref_mem_en,
  input  logic [31:0] ref_mem_addr,
  output logic [31:0] cur_in_i,
  output logic [63:0] ref_in_i,
  output logic        serving,
  output logic        addr_err,
  output logic [15:0] rd_cnt
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_SERVE  = 1'b1;
  localparam logic [31:0] CUR_DEPTH = 32'd1 << CUR_AW;
  localparam logic [31:0] REF_DEPTH = 32'd1 << REF_AW;

  logic [0:0]  state_q, state_d;
  logic [31:0] cur_q, cur_d;
  logic [63:0] ref_q, ref_d;
  logic        err_q, err_d;

  logic [31:0] cur_mem [2**CUR_AW];
  logic [63:0] ref_mem [2**REF_AW];

  logic is_serve, ld_fire, ld_ok, cur_ok, ref_ok, go_fire;

  assign is_serve = (state_q == ST_SERVE);
  assign ld_ready = (state_q == ST_IDLE);
  assign ld_fire  = ld_valid & ld_ready;
  assign ld_ok    = ld_sel ? (ld_addr < REF_DEPTH) : (ld_addr < CUR_DEPTH);
  assign cur_ok   = is_serve & (cur_mem_addr < CUR_DEPTH);
  assign ref_ok   = is_serve & (ref_mem_addr < REF_DEPTH);
  assign go_fire  = ~is_serve & go_i;

  always_comb begin
    state_d = state_q;
    if (go_fire)                state_d = ST_SERVE;
    else if (is_serve & stop_i) state_d = ST_IDLE;
  end

  // Out-of-range or IDLE reads return zero; disabled ports hold their last word.
  always_comb begin
    cur_d = cur_q;
    ref_d = ref_q;
    err_d = err_q;
    if (cur_mem_en) begin
      cur_d = cur_ok ? cur_mem[cur_mem_addr[CUR_AW-1:0]] : 32'h0;
      if (!cur_ok) err_d = 1'b1;
    end
    if (ref_mem_en) begin
      ref_d = ref_ok ? ref_mem[ref_mem_addr[REF_AW-1:0]] : 64'h0;
      if (!ref_ok) err_d = 1'b1;
    end
    if (ld_fire && !ld_ok) err_d = 1'b1;
  end

  // Banks are never cleared; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && ld_fire && ld_ok) begin
      if (ld_sel) ref_mem[ld_addr[REF_AW-1:0]] <= ld_data;
      else        cur_mem[ld_addr[CUR_AW-1:0]] <= ld_data[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cur_q   <= 32'h0;
      ref_q   <= 64'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ref_q   <= ref_d;
      err_q   <= err_d;
    end
  end

  assign cur_in_i = cur_q;
  assign ref_in_i = ref_q;
  assign serving  = is_serve;
  assign addr_err = err_q;

`ifdef ME_MEM_RDCNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  n_rd;
  logic [16:0] sum;

  assign n_rd = {1'b0, is_serve & cur_mem_en} + {1'b0, is_serve & ref_mem_en};
  assign sum  = {1'b0, cnt_q} + {15'h0, n_rd};

  always_comb begin
    cnt_d = sum[16] ? 16'hFFFF : sum[15:0];
    if (go_fire) cnt_d = 16'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= 16'h0;
    else      cnt_q <= cnt_d;
  end

  assign rd_cnt = cnt_q;
`else
  assign rd_cnt = 16'h0000;
`endif

endmodule
